// File: rtl/encoder_32to5_scan_pkg.sv
// Shared types and helpers for the 32-to-5 scanning encoder.
package enc_pkg;
  localparam int unsigned N_IN  = 32;
  localparam int unsigned W_OUT = 5;

  typedef enum logic {ST_IDLE, ST_EMIT} state_t;

  function automatic logic popcount_is_one(input logic [N_IN-1:0] v);
    return (v != '0) && ((v & (v - N_IN'(1))) == '0);
  endfunction
endpackage

// File: rtl/encoder_32to5_scan_if.sv
// Input-vector and index-output handshake bundle for encoder_32to5_scan.
interface encoder_32to5_scan_if;
  import enc_pkg::*;

  logic [N_IN-1:0]  din;
  logic             din_valid;
  logic             din_ready;
  logic [W_OUT-1:0] dout;
  logic             dout_valid;
  logic             dout_ready;
  logic             dout_last;

  modport slave (
    input  din, din_valid, dout_ready,
    output din_ready, dout, dout_valid, dout_last
  );

  modport master (
    output din, din_valid, dout_ready,
    input  din_ready, dout, dout_valid, dout_last
  );
endinterface

// File: rtl/encoder_32to5_scan_prio.sv
// Combinational 32-to-5 priority encoder; MSB_FIRST selects the winning end.
module prio_enc_32
  import enc_pkg::*;
#(
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic [N_IN-1:0]  vec,
  output logic [W_OUT-1:0] idx,
  output logic             any
);

  // Later assignments override earlier ones, so the loop order sets the priority.
  always_comb begin
    idx = '0;
    any = |vec;
    for (int unsigned i = 0; i < N_IN; i++) begin
      if (MSB_FIRST) begin
        if (vec[i]) idx = W_OUT'(i);
      end else begin
        if (vec[N_IN-1-i]) idx = W_OUT'(N_IN-1-i);
      end
    end
  end

endmodule

// File: rtl/encoder_32to5_scan.sv
// Scanning encoder: emits the index of each set bit of a captured vector.
// Build option: define ENC_MSB_FIRST_EN to scan highest index first.
module encoder_32to5_scan
  import enc_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en,
  encoder_32to5_scan_if.slave    bus,
  output logic                   none,
  output logic                   busy
);

`ifdef ENC_MSB_FIRST_EN
  localparam bit MSB_FIRST = 1'b1;
`else
  localparam bit MSB_FIRST = 1'b0;
`endif

  state_t           state, state_nx;
  logic [N_IN-1:0]  pend, pend_nx, clr;
  logic [W_OUT-1:0] sel;
  logic             any;
  logic             none_nx;

  prio_enc_32 #(.MSB_FIRST(MSB_FIRST)) u_prio (
    .vec(pend),
    .idx(sel),
    .any(any)
  );

  assign bus.dout       = sel;
  assign bus.dout_valid = (state == ST_EMIT);
  assign busy           = (state == ST_EMIT);
  assign bus.dout_last  = (state == ST_EMIT) && popcount_is_one(pend);
  assign bus.din_ready  = en && rst_n && (state == ST_IDLE);

  always_comb begin
    state_nx = state;
    pend_nx  = pend;
    none_nx  = 1'b0;
    clr      = '0;
    clr[sel] = 1'b1;
    if (!en) begin
      state_nx = ST_IDLE;
      pend_nx  = '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (bus.din_valid) begin
            pend_nx = bus.din;
            if (bus.din != '0) state_nx = ST_EMIT;
            else               none_nx  = 1'b1;
          end
        end
        ST_EMIT: begin
          if (bus.dout_ready && any) begin
            pend_nx = pend & ~clr;
            if (bus.dout_last) state_nx = ST_IDLE;
          end
        end
        default: state_nx = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      pend  <= '0;
      none  <= 1'b0;
    end else begin
      state <= state_nx;
      pend  <= pend_nx;
      none  <= none_nx;
    end
  end

endmodule

// File: doc/encoder_32to5_scan.md
# encoder_32to5_scan

Sequential scanning encoder: the inverse of the 5-to-32 row decoder in the RRAM periphery. It accepts a 32-bit multi-hot row-flag vector, for example sense-amp match lines or row-fault flags from the array. It then emits the 5-bit index of every set bit, one per accepted handshake, in priority order. Downstream logic uses the indices to re-address flagged rows through the decoder.

## Interface
- N_IN, default 32: width of the input vector; fixed at 32 for this block.
- W_OUT, default 5: index width, equal to clog2(N_IN).
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- en  in  1  block enable; low forces idle and aborts any scan.
- din  in  32  flag vector; bit i set means row i is flagged.
- din_valid  in  1  din is presented.
- din_ready  out  1  block can capture a vector.
- dout  out  5  index of the currently selected set bit.
- dout_valid  out  1  dout is valid.
- dout_ready  in  1  consumer accepts dout.
- dout_last  out  1  dout is the final index of the captured vector.
- none  out  1  one-cycle pulse when a captured vector was all-zero.
- busy  out  1  high while a vector is being scanned.

## Operation
- The 32-bit register pend holds the bits not yet emitted.
- States are IDLE and EMIT.
- **IDLE**
  - din_ready = en.
  - On din_valid && din_ready, load pend <= din.
  - If din != 0: go to EMIT; dout_valid and busy rise next cycle.
  - If din == 0: stay in IDLE; pulse none for exactly one cycle (the cycle after capture); no dout_valid.
- **EMIT**
  - din_ready = 0.
  - dout_valid = 1.
  - dout = index of the lowest set bit of pend.
  - dout_last = 1 when pend has exactly one bit set.
- **Handshake in EMIT:** on dout_valid && dout_ready, clear the bit at index dout in pend.
  - If dout_last: go to IDLE.
  - Otherwise stay in EMIT; dout updates to the next index on the following cycle.
- dout, dout_last and dout_valid stay stable while dout_valid && !dout_ready. The consumer may hold off indefinitely.
- **en low:** at the next edge, pend <= 0, state <= IDLE, dout_valid, busy and none deassert, and no index is emitted. This also aborts a scan in progress.
- din is ignored whenever din_ready is low.
- **All-ones vector:** 32 emissions, indices 0 through 31; dout_last is high only with index 31.

## Timing
- **Reset values:** state IDLE, pend 0, dout 0, dout_valid 0, dout_last 0, none 0, busy 0. din_ready follows en once reset is released.
- **Latency:** capture at edge k, first dout_valid in cycle k+1.
- **Throughput:** one index per cycle while dout_ready is held high.
- **Back-to-back vectors:** after the last handshake at edge m, din_ready is high in cycle m+1. There is one idle cycle between vectors.
- dout, dout_last and busy are registered or derived from registered state. dout_valid and busy are equal.
- none is registered and high only in cycle k+1.
- **Simultaneous handshake and en drop:** the abort wins; the bit is treated as not consumed.
- **Reset asserted mid-scan:** all outputs return to their reset values immediately, without waiting for a clock.

## Configuration
- Macro: ENC_MSB_FIRST_EN.
- **Defined:** scan order is highest index first. dout is the highest set bit of pend, and dout_last is tied to the lowest remaining bit.
- **Undefined (default):** scan order is lowest index first, as described above.
- Handshake, timing and all other behaviour are identical in both builds.

## Structure
- Package enc_pkg holds:
  - localparams N_IN = 32 and W_OUT = 5;
  - the state enum (ST_IDLE, ST_EMIT);
  - a popcount-is-one helper function used for dout_last.
- One sub-module, prio_enc_32:
  - combinational 32-to-5 priority encoder;
  - scan direction selected by a parameter driven from ENC_MSB_FIRST_EN;
  - outputs the index and an any-set flag.
- The top level contains the FSM, the pend register and the handshake logic.

## Test plan
- **Reset and idle:**
  - stimulus: rst_n low with en = 1;
  - response: all outputs are 0; din_ready is 1 after rst_n rises.
- **Sparse vector:**
  - stimulus: din = 32'h8000_0021, dout_ready held at 1;
  - response (LSB-first): dout = 0, 5, 31 in consecutive cycles, with dout_last only on 31;
  - response (ENC_MSB_FIRST_EN): dout = 31, 5, 0, with dout_last only on 0.
- **Zero vector:**
  - stimulus: din = 0 captured;
  - response: none = 1 for one cycle, no dout_valid, din_ready stays 1.
- **Backpressure:**
  - stimulus: din = 32'h0000_0006, dout_ready low for 5 cycles, then high;
  - response: dout holds 1 with dout_valid high throughout the stall, then 2 with dout_last = 1.
- **Abort:**
  - stimulus: din = 32'hFFFF_FFFF; drop en after 3 handshakes;
  - response: indices 0, 1, 2 emitted; next cycle dout_valid = 0 and busy = 0; after en returns, a new din = 32'h0000_0010 yields only dout = 4 with dout_last = 1.
- **Full sweep:**
  - stimulus: each one-hot din (1 << i) for i = 0 to 31;
  - response: a single dout = i with dout_last = 1; this cross-checks against the decoder's one-hot outputs.
